// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs, time base and status outputs of the traffic light monitor.
interface traffic_light_monitor_if #(
    parameter int unsigned TICK_W = 4
);
    logic              tick;
    logic              main_r;
    logic              main_y;
    logic              main_g;
    logic              side_r;
    logic              side_y;
    logic              side_g;
    logic              clear_err;
    logic [2:0]        phase_code;
    logic              phase_change;
    logic [TICK_W-1:0] last_duration;
    logic              walk_active;
    logic              err_lamp;
    logic              err_sequence;
    logic              err_timing;

    // Side that drives the lamps and observes the status.
    modport master (
        output tick, main_r, main_y, main_g, side_r, side_y, side_g, clear_err,
        input  phase_code, phase_change, last_duration, walk_active,
        input  err_lamp, err_sequence, err_timing
    );

    // The monitor itself.
    modport slave (
        input  tick, main_r, main_y, main_g, side_r, side_y, side_g, clear_err,
        output phase_code, phase_change, last_duration, walk_active,
        output err_lamp, err_sequence, err_timing
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the six intersection lamps: decodes the lamps into a
// phase, times each phase in ticks and raises sticky error flags.
module traffic_light_monitor #(
    parameter int unsigned TICK_W     = 4,
    parameter int unsigned MIN_GREEN  = 3,
    parameter int unsigned MIN_YELLOW = 2
) (
    input logic                    clock,
    input logic                    reset,
    traffic_light_monitor_if.slave bus
);
    typedef enum logic [2:0] {
        PhDark    = 3'd0,
        PhMg      = 3'd1,
        PhMy      = 3'd2,
        PhAr      = 3'd3,
        PhSg      = 3'd4,
        PhSy      = 3'd5,
        PhIllegal = 3'd7
    } phase_e;

    localparam logic [TICK_W-1:0] CntMax    = {TICK_W{1'b1}};
    localparam logic [TICK_W-1:0] MinGreen  = TICK_W'(MIN_GREEN);
    localparam logic [TICK_W-1:0] MinYellow = TICK_W'(MIN_YELLOW);

    logic [5:0]        lamp_q;
    phase_e            lamp_phase;
    phase_e            phase_q, phase_d;
    logic [TICK_W-1:0] count_q, count_d;
    logic [TICK_W-1:0] last_q, last_d;
    logic              change_q, change_d;
    logic              walk_q, walk_d;
    logic              err_lamp_q, err_lamp_d;
    logic              err_seq_q, err_seq_d;
    logic              err_time_q, err_time_d;
    logic              set_lamp, set_seq, set_time;

    // Lamp order {main_r, main_y, main_g, side_r, side_y, side_g}.
    function automatic phase_e decode(input logic [5:0] lamps);
        phase_e ph;
        case (lamps)
            6'b000_000: ph = PhDark;
            6'b001_100: ph = PhMg;
            6'b010_100: ph = PhMy;
            6'b100_100: ph = PhAr;
            6'b100_001: ph = PhSg;
            6'b100_010: ph = PhSy;
            default:    ph = PhIllegal;
        endcase
        return ph;
    endfunction

    function automatic logic legal_step(input phase_e cur, input phase_e nxt);
        logic ok;
        ok = 1'b0;
        if (nxt == PhDark) begin
            ok = 1'b1;
        end else begin
            case (cur)
                PhDark:  ok = (nxt == PhMg);
                PhMg:    ok = (nxt == PhMy);
                PhMy:    ok = (nxt == PhAr) || (nxt == PhSg);
                PhAr:    ok = (nxt == PhSg);
                PhSg:    ok = (nxt == PhSy);
                PhSy:    ok = (nxt == PhMg);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Stage 1: capture the raw lamps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lamp_q <= '0;
        end else begin
            lamp_q <= {bus.main_r, bus.main_y, bus.main_g, bus.side_r, bus.side_y, bus.side_g};
        end
    end

    // Stage 2 next state: phase change detection, duration timing and error flags.
    always_comb begin
        lamp_phase = decode(lamp_q);
        phase_d    = lamp_phase;
        count_d    = count_q;
        last_d     = last_q;
        change_d   = 1'b0;
        set_lamp   = 1'b0;
        set_seq    = 1'b0;
        set_time   = 1'b0;
        if (lamp_phase != phase_q) begin
            change_d = 1'b1;
            last_d   = count_q;
            // A tick in the change cycle already belongs to the new phase.
            count_d  = bus.tick ? TICK_W'(1) : '0;
            if (lamp_phase == PhIllegal || phase_q == PhIllegal) begin
                set_lamp = 1'b1;
            end else if (!legal_step(phase_q, lamp_phase)) begin
                set_seq = 1'b1;
            end
            case (phase_q)
                PhMg, PhSg: set_time = (count_q < MinGreen);
                PhMy, PhSy: set_time = (count_q < MinYellow);
                default:    set_time = 1'b0;
            endcase
        end else if (bus.tick && count_q != CntMax) begin
            count_d = count_q + 1'b1;
        end
        walk_d     = (phase_d == PhAr);
        // Set wins over a simultaneous clear.
        err_lamp_d = set_lamp | (err_lamp_q & ~bus.clear_err);
        err_seq_d  = set_seq  | (err_seq_q  & ~bus.clear_err);
        err_time_d = set_time | (err_time_q & ~bus.clear_err);
    end

    // Stage 2 state register; every output comes straight from here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q    <= PhDark;
            count_q    <= '0;
            last_q     <= '0;
            change_q   <= 1'b0;
            walk_q     <= 1'b0;
            err_lamp_q <= 1'b0;
            err_seq_q  <= 1'b0;
            err_time_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            count_q    <= count_d;
            last_q     <= last_d;
            change_q   <= change_d;
            walk_q     <= walk_d;
            err_lamp_q <= err_lamp_d;
            err_seq_q  <= err_seq_d;
            err_time_q <= err_time_d;
        end
    end

    assign bus.phase_code    = phase_q;
    assign bus.phase_change  = change_q;
    assign bus.last_duration = last_q;
    assign bus.walk_active   = walk_q;
    assign bus.err_lamp      = err_lamp_q;
    assign bus.err_sequence  = err_seq_q;
    assign bus.err_timing    = err_time_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed lamp sequences, a phase-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_traffic_light_monitor;
    localparam logic [5:0] P_DARK = 6'b000_000;
    localparam logic [5:0] P_MG   = 6'b001_100;
    localparam logic [5:0] P_MY   = 6'b010_100;
    localparam logic [5:0] P_AR   = 6'b100_100;
    localparam logic [5:0] P_SG   = 6'b100_001;
    localparam logic [5:0] P_SY   = 6'b100_010;
    localparam logic [5:0] P_GG   = 6'b001_001;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    traffic_light_monitor_if #(.TICK_W(4)) bus ();

    traffic_light_monitor #(
        .TICK_W    (4),
        .MIN_GREEN (3),
        .MIN_YELLOW(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Phase-level reference: lookup tables plus an unbounded tick count.
    int        decode_tbl [64];
    bit        allowed    [8][8];
    int        m_phase, m_time, m_last;
    bit        m_change, m_el, m_es, m_et;
    logic [5:0] m_s1;

    // Observations of the DUT, compared against hand-computed literals.
    int pulse_cnt   = 0;
    int walk_cnt    = 0;
    int illegal_cnt = 0;
    int pulse_log[$];

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_step();
        int np;
        bit sl, ss, st;
        logic [5:0] now_lamps;
        now_lamps = {bus.main_r, bus.main_y, bus.main_g, bus.side_r, bus.side_y, bus.side_g};
        if (!reset) begin
            m_phase = 0; m_time = 0; m_last = 0; m_change = 0;
            m_el = 0; m_es = 0; m_et = 0; m_s1 = '0;
            return;
        end
        np = decode_tbl[m_s1];
        sl = 0; ss = 0; st = 0;
        if (np != m_phase) begin
            m_change = 1;
            m_last   = (m_time > 15) ? 15 : m_time;
            if (np == 7 || m_phase == 7) sl = 1;
            else if (!allowed[m_phase][np]) ss = 1;
            if ((m_phase == 1 || m_phase == 4) && m_time < 3) st = 1;
            if ((m_phase == 2 || m_phase == 5) && m_time < 2) st = 1;
            m_time = int'(bus.tick);
        end else begin
            m_change = 0;
            m_time   = m_time + int'(bus.tick);
        end
        m_el    = sl | (m_el & !bus.clear_err);
        m_es    = ss | (m_es & !bus.clear_err);
        m_et    = st | (m_et & !bus.clear_err);
        m_phase = np;
        m_s1    = now_lamps;
    endtask

    // One clock: drive inputs, let the edge consume them, step the model.
    task automatic cyc(input logic [5:0] p, input logic tk, input logic clr);
        {bus.main_r, bus.main_y, bus.main_g, bus.side_r, bus.side_y, bus.side_g} = p;
        bus.tick      = tk;
        bus.clear_err = clr;
        @(posedge clock);
        model_step();
        #1;
    endtask

    // Hold a pattern: three tick-free lead cycles, then n ticks one cycle apart.
    task automatic hold(input logic [5:0] p, input int n);
        repeat (3) cyc(p, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            cyc(p, 1'b1, 1'b0);
            cyc(p, 1'b0, 1'b0);
        end
    endtask

    // Every-cycle comparison against the model (all zero while in reset).
    always @(negedge clock) begin
        check("phase_code",    int'(bus.phase_code),    reset ? m_phase : 0);
        check("phase_change",  int'(bus.phase_change),  reset ? int'(m_change) : 0);
        check("last_duration", int'(bus.last_duration), reset ? m_last : 0);
        check("walk_active",   int'(bus.walk_active),   reset ? int'(m_phase == 3) : 0);
        check("err_lamp",      int'(bus.err_lamp),      reset ? int'(m_el) : 0);
        check("err_sequence",  int'(bus.err_sequence),  reset ? int'(m_es) : 0);
        check("err_timing",    int'(bus.err_timing),    reset ? int'(m_et) : 0);
    end

    always @(negedge clock) begin
        if (bus.phase_change) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_log.push_back(int'(bus.last_duration));
        end
        if (bus.walk_active) walk_cnt <= walk_cnt + 1;
        if (bus.phase_code == 3'd7) illegal_cnt <= illegal_cnt + 1;
    end

    task automatic check_errs(input string tag, input int el, input int es, input int et);
        check({tag, "_err_lamp"},     int'(bus.err_lamp),     el);
        check({tag, "_err_sequence"}, int'(bus.err_sequence), es);
        check({tag, "_err_timing"},   int'(bus.err_timing),   et);
    endtask

    initial begin
        int base;
        int lbase;
        foreach (decode_tbl[i]) decode_tbl[i] = 7;
        decode_tbl[P_DARK] = 0; decode_tbl[P_MG] = 1; decode_tbl[P_MY] = 2;
        decode_tbl[P_AR]   = 3; decode_tbl[P_SG] = 4; decode_tbl[P_SY] = 5;
        foreach (allowed[i, j]) allowed[i][j] = 0;
        for (int i = 0; i < 8; i++) allowed[i][0] = 1;
        allowed[0][1] = 1; allowed[1][2] = 1; allowed[2][3] = 1; allowed[2][4] = 1;
        allowed[3][4] = 1; allowed[4][5] = 1; allowed[5][1] = 1;
        m_phase = 0; m_time = 0; m_last = 0; m_change = 0;
        m_el = 0; m_es = 0; m_et = 0; m_s1 = '0;

        // 1: reset held for five clocks, then release with no pulse.
        reset = 1'b0;
        repeat (5) cyc(P_MG, 1'b1, 1'b0);
        check("rst_phase_code", int'(bus.phase_code), 0);
        check("rst_last_duration", int'(bus.last_duration), 0);
        check("rst_phase_change", int'(bus.phase_change), 0);
        check_errs("rst", 0, 0, 0);
        reset = 1'b1;
        base = pulse_cnt;
        cyc(P_DARK, 1'b1, 1'b0); cyc(P_DARK, 1'b0, 1'b0);
        cyc(P_DARK, 1'b1, 1'b0); cyc(P_DARK, 1'b0, 1'b0);
        check("release_no_pulse", pulse_cnt - base, 0);
        check("release_dark", int'(bus.phase_code), 0);

        // 2: full main/side cycle; first MG entry reports the DARK time.
        lbase = pulse_log.size();
        hold(P_MG, 6);
        check("dark_to_mg_pulses", pulse_log.size() - lbase, 1);
        check("dark_duration", pulse_log[lbase], 2);
        lbase = pulse_log.size();
        hold(P_MY, 2); hold(P_SG, 6); hold(P_SY, 2); hold(P_MG, 4);
        check("cycle_pulses", pulse_log.size() - lbase, 4);
        check("cycle_dur0", pulse_log[lbase],     6);
        check("cycle_dur1", pulse_log[lbase + 1], 2);
        check("cycle_dur2", pulse_log[lbase + 2], 6);
        check("cycle_dur3", pulse_log[lbase + 3], 2);
        check_errs("cycle", 0, 0, 0);

        // 3: walk interval of 3 ticks.
        base = walk_cnt;
        hold(P_MY, 2); hold(P_AR, 3); hold(P_SG, 4);
        check("walk_cycles", walk_cnt - base, 9);
        check("walk_duration", int'(bus.last_duration), 3);
        check("walk_off", int'(bus.walk_active), 0);
        check_errs("walk", 0, 0, 0);
        hold(P_SY, 2); hold(P_MG, 4);

        // 4: one clock of both greens.
        base = illegal_cnt;
        cyc(P_GG, 1'b0, 1'b0);
        hold(P_MG, 4);
        check("illegal_cycles", illegal_cnt - base, 1);
        check("illegal_back_mg", int'(bus.phase_code), 1);
        check_errs("illegal", 1, 0, 0);

        // 5: sequence error, short yellow, then set-vs-clear priority.
        hold(P_SG, 4);
        check_errs("seq", 1, 1, 0);
        hold(P_MY, 1);
        check("short_y_before", int'(bus.err_timing), 0);
        hold(P_AR, 2);
        check("short_y_after", int'(bus.err_timing), 1);
        cyc(P_AR, 1'b0, 1'b1);
        check_errs("cleared", 0, 0, 0);
        cyc(P_MG, 1'b0, 1'b0);
        cyc(P_MG, 1'b0, 1'b1);
        check("set_beats_clear", int'(bus.err_sequence), 1);
        cyc(P_MG, 1'b0, 1'b1);
        check("clear_after", int'(bus.err_sequence), 0);

        // 6: saturation, then asynchronous reset in SG.
        for (int i = 0; i < 20; i++) begin
            cyc(P_MG, 1'b1, 1'b0);
            cyc(P_MG, 1'b0, 1'b0);
        end
        hold(P_MY, 2);
        check("saturated_duration", int'(bus.last_duration), 15);
        hold(P_SG, 2);
        check("pre_reset_phase", int'(bus.phase_code), 4);
        check("pre_reset_last", int'(bus.last_duration), 2);
        #1 reset = 1'b0;
        #1;
        check("async_phase_code", int'(bus.phase_code), 0);
        check("async_last_duration", int'(bus.last_duration), 0);
        check("async_phase_change", int'(bus.phase_change), 0);
        check("async_walk_active", int'(bus.walk_active), 0);
        check_errs("async", 0, 0, 0);
        repeat (2) cyc(P_SG, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) cyc(P_DARK, 1'b1, 1'b0);
        check("post_reset_dark", int'(bus.phase_code), 0);
        check("post_reset_no_pulse", int'(bus.phase_change), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
